// File: rtl/mod_pmc_multi_if.sv
// Data/instruction bus bundle for mod_pmc_multi. The master drives addresses,
// strobes and write data; the peripheral (slave) returns read data.
interface mod_pmc_multi_if;
  logic        ie;
  logic        de;
  logic [31:0] iaddr;
  logic [31:0] daddr;
  logic [1:0]  drw;
  logic [31:0] din;
  logic [31:0] iout;
  logic [31:0] dout;

  modport master (output ie, de, iaddr, daddr, drw, din, input iout, dout);
  modport slave  (input ie, de, iaddr, daddr, drw, din, output iout, dout);
endinterface

// File: rtl/mod_pmc_multi.sv
// Performance-monitor counter bank: N_CH event counters with per-channel enable,
// wrap/saturate mode, sticky overflow flags with interrupt and an atomic snapshot.
module mod_pmc_multi #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  mod_pmc_multi_if.slave   bus,
  input  logic [N_CH-1:0]  ev,
  output logic             ovf_int
);

  localparam logic [31:0]      A_EN     = 32'h100;
  localparam logic [31:0]      A_OVF    = 32'h104;
  localparam logic [31:0]      A_OVF_IE = 32'h108;
  localparam logic [31:0]      A_MODE   = 32'h10C;
  localparam logic [31:0]      A_CMD    = 32'h110;
  localparam logic [31:0]      A_SNAP   = 32'h200;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] cnt     [N_CH];
  logic [CNT_W-1:0] snap    [N_CH];
  logic [CNT_W-1:0] cnt_nxt [N_CH];
  logic [N_CH-1:0]  en;
  logic [N_CH-1:0]  ovf;
  logic [N_CH-1:0]  ovf_ie;
  logic [N_CH-1:0]  ovf_set;
  logic             mode;
  logic             wr;
  logic             cmd_clr;
  logic             cmd_snap;
  logic             unused_ok;

  // Saturate holds at all-ones; wrap rolls over to zero.
  function automatic logic [CNT_W-1:0] step_cnt(input logic [CNT_W-1:0] c,
                                                input logic sat);
    if (c == CNT_MAX) return sat ? c : '0;
    return c + CNT_W'(1);
  endfunction

  assign wr       = bus.de && bus.drw[0];
  assign cmd_clr  = wr && (bus.daddr == A_CMD) && bus.din[0];
  assign cmd_snap = wr && (bus.daddr == A_CMD) && bus.din[1];
  assign bus.iout = '0;
  assign unused_ok = ^{bus.ie, bus.iaddr, bus.drw[1], bus.din};

  // A clear or direct write swallows the event of that cycle, so no overflow is flagged.
  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (cmd_clr) begin
        cnt_nxt[i] = '0;
      end else if (wr && (bus.daddr == 32'(4 * i))) begin
        cnt_nxt[i] = bus.din[CNT_W-1:0];
      end else if (en[i] && ev[i]) begin
        cnt_nxt[i] = step_cnt(cnt[i], mode);
        ovf_set[i] = (cnt[i] == CNT_MAX);
      end
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i]  <= '0;
        snap[i] <= '0;
      end
      en      <= '1;
      ovf     <= '0;
      ovf_ie  <= '0;
      mode    <= 1'b0;
      ovf_int <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= cnt_nxt[i];
        if (cmd_snap) snap[i] <= cnt[i];
      end
      if (wr && (bus.daddr == A_EN))     en     <= bus.din[N_CH-1:0];
      if (wr && (bus.daddr == A_OVF_IE)) ovf_ie <= bus.din[N_CH-1:0];
      if (wr && (bus.daddr == A_MODE))   mode   <= bus.din[0];
      // Set beats a simultaneous write-1-to-clear.
      if (wr && (bus.daddr == A_OVF)) ovf <= (ovf & ~bus.din[N_CH-1:0]) | ovf_set;
      else                            ovf <= ovf | ovf_set;
      ovf_int <= |(ovf & ovf_ie);
    end
  end

  always_comb begin
    bus.dout = '0;
    case (bus.daddr)
      A_EN:     bus.dout = 32'(en);
      A_OVF:    bus.dout = 32'(ovf);
      A_OVF_IE: bus.dout = 32'(ovf_ie);
      A_MODE:   bus.dout = {31'd0, mode};
      default:  bus.dout = '0;
    endcase
    for (int i = 0; i < N_CH; i++) begin
      if (bus.daddr == 32'(4 * i))          bus.dout = 32'(cnt[i]);
      if (bus.daddr == A_SNAP + 32'(4 * i)) bus.dout = 32'(snap[i]);
    end
  end

endmodule

// File: tb/tb_mod_pmc_multi.sv
// Directed bench for mod_pmc_multi (N_CH=8, CNT_W=8) with a read-data scoreboard.
module tb_mod_pmc_multi;
  logic       clk = 1'b1;
  logic       rst;
  logic [7:0] ev;
  logic       ovf_int;
  int         compared = 0;
  int         mismatched = 0;
  logic [31:0] exp_q[$];

  mod_pmc_multi_if bus();

  mod_pmc_multi #(.N_CH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ev(ev), .ovf_int(ovf_int)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // State is captured on the falling edge; look just after it.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.daddr = addr; bus.din = data; bus.de = 1'b1; bus.drw = 2'b01;
    cyc();
    bus.de = 1'b0; bus.drw = 2'b00; bus.din = '0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    bus.daddr = addr; bus.de = 1'b1; bus.drw = 2'b10;
    #1;
    e = exp_q.pop_front();
    check(tag, bus.dout, e);
    bus.de = 1'b0; bus.drw = 2'b00;
  endtask

  initial begin
    rst = 1'b1; ev = '0;
    bus.ie = 1'b0; bus.iaddr = '0; bus.de = 1'b0; bus.drw = '0;
    bus.daddr = '0; bus.din = '0;
    cyc(2);
    rst = 1'b0;

    // Reset state and basic counting
    rd("rst_cnt0", 32'h000, 32'h0);
    rd("rst_en", 32'h100, 32'hFF);
    rd("rst_ovf", 32'h104, 32'h0);
    rd("rst_mode", 32'h10C, 32'h0);
    rd("rst_snap0", 32'h200, 32'h0);
    check("rst_iout", bus.iout, 32'h0);
    check("rst_int", {31'd0, ovf_int}, 32'h0);
    ev = 8'h01;
    cyc(5);
    ev = '0;
    rd("cnt0_5", 32'h000, 32'h5);
    rd("en_ones", 32'h100, 32'hFF);
    rd("cmd_rd0", 32'h110, 32'h0);
    check("int_idle", {31'd0, ovf_int}, 32'h0);

    // Wrap overflow and registered interrupt
    wr(32'h004, 32'hFE);
    wr(32'h10C, 32'h0);
    wr(32'h108, 32'h02);
    ev = 8'h02;
    cyc(2);
    check("int_lag", {31'd0, ovf_int}, 32'h0);
    cyc();
    ev = '0;
    check("int_rise", {31'd0, ovf_int}, 32'h1);
    rd("wrap_cnt1", 32'h004, 32'h01);
    rd("wrap_ovf", 32'h104, 32'h02);
    wr(32'h104, 32'h02);
    rd("w1c_ovf", 32'h104, 32'h0);
    cyc();
    check("int_drop", {31'd0, ovf_int}, 32'h0);

    // Saturate mode
    wr(32'h10C, 32'h1);
    wr(32'h004, 32'hFE);
    ev = 8'h02;
    cyc(3);
    ev = '0;
    rd("sat_cnt1", 32'h004, 32'hFF);
    rd("sat_ovf", 32'h104, 32'h02);
    cyc();
    check("sat_int", {31'd0, ovf_int}, 32'h1);
    wr(32'h104, 32'h02);
    rd("sat_w1c", 32'h104, 32'h0);
    check("sat_int_hold", {31'd0, ovf_int}, 32'h1);
    cyc();
    check("sat_int_drop", {31'd0, ovf_int}, 32'h0);
    wr(32'h10C, 32'h0);

    // Enable mask and write-beats-event
    wr(32'h100, 32'h01);
    wr(32'h110, 32'h1);
    rd("clr_cnt1", 32'h004, 32'h0);
    ev = 8'hFF;
    cyc(10);
    rd("en_cnt0", 32'h000, 32'h0A);
    rd("en_cnt1", 32'h004, 32'h0);
    rd("en_cnt7", 32'h01C, 32'h0);
    wr(32'h000, 32'h40);
    ev = '0;
    rd("wr_vs_ev", 32'h000, 32'h40);

    // Snapshot combined with clear
    wr(32'h100, 32'hFF);
    wr(32'h008, 32'h07);
    ev = 8'h04;
    wr(32'h110, 32'h3);
    ev = '0;
    rd("snap2", 32'h208, 32'h07);
    rd("snap0", 32'h200, 32'h40);
    rd("clr_cnt2", 32'h008, 32'h0);
    ev = 8'h04;
    cyc(2);
    ev = '0;
    rd("post_cnt2", 32'h008, 32'h02);
    rd("post_snap2", 32'h208, 32'h07);

    // Overflow set beats same-cycle clear; unmapped offset is inert
    wr(32'h00C, 32'hFF);
    ev = 8'h08;
    wr(32'h104, 32'h08);
    ev = '0;
    rd("set_wins", 32'h104, 32'h08);
    rd("wrap_cnt3", 32'h00C, 32'h0);
    rd("hole_rd", 32'h1F0, 32'h0);
    wr(32'h1F0, 32'hFFFF_FFFF);
    rd("hole_en", 32'h100, 32'hFF);
    rd("hole_ovf", 32'h104, 32'h08);
    rd("hole_mode", 32'h10C, 32'h0);
    rd("hole_cnt2", 32'h008, 32'h02);

    // Reset in the middle of counting
    ev = 8'hFF;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ev = '0;
    rd("mid_cnt0", 32'h000, 32'h0);
    rd("mid_snap2", 32'h208, 32'h0);
    rd("mid_ovf", 32'h104, 32'h0);
    rd("mid_en", 32'h100, 32'hFF);
    check("mid_int", {31'd0, ovf_int}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
